// File: rtl/cpich_sched_pkg.sv
// ============================================================================
// cpich_sched_pkg
// Shared state encoding and default timing constants for the CPICH scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpich_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ARM  = 4'b0010,
        S_RUN  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam int c_DEF_MIC_LEN        = 32;
    localparam int c_DEF_SF             = 256;
    localparam int c_DEF_SYM_PER_SLOT   = 10;
    localparam int c_DEF_SLOT_PER_FRAME = 15;
    localparam int c_DEF_MIN_ARM        = 64;

    // Clock cycles per radio frame with the default chain: 1,228,800.
    localparam int c_FRAME_PERIOD = c_DEF_MIC_LEN * c_DEF_SF *
                                    c_DEF_SYM_PER_SLOT * c_DEF_SLOT_PER_FRAME;

endpackage

`default_nettype wire

// File: rtl/cpich_chip_counter.sv
// ============================================================================
// cpich_chip_counter
// Cascaded micro-cycle/chip/symbol/slot counter with frame-sync clear and
// terminal decodes. Optional slot_last under CPICH_SCHED_SLOT_STROBE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpich_chip_counter
    import cpich_sched_pkg::*;
#(
    parameter int MIC_LEN        = c_DEF_MIC_LEN,
    parameter int SF             = c_DEF_SF,
    parameter int SYM_PER_SLOT   = c_DEF_SYM_PER_SLOT,
    parameter int SLOT_PER_FRAME = c_DEF_SLOT_PER_FRAME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_sync,
    output logic [4:0] counter_mic,
    output logic [7:0] counter_256,
    output logic [3:0] counter_10,
    output logic [3:0] counter_15,
    output logic       frame_head,
    output logic       frame_end,
`ifdef CPICH_SCHED_SLOT_STROBE_EN
    output logic       slot_last,
`endif
    output logic       frame_last
);

    logic [4:0] r_mic;
    logic [7:0] r_chip;
    logic [3:0] r_sym;
    logic [3:0] r_slot;

    logic w_mic_tc;
    logic w_chip_tc;
    logic w_sym_tc;
    logic w_slot_tc;

    assign w_mic_tc  = (r_mic  == 5'(MIC_LEN - 1));
    assign w_chip_tc = (r_chip == 8'(SF - 1));
    assign w_sym_tc  = (r_sym  == 4'(SYM_PER_SLOT - 1));
    assign w_slot_tc = (r_slot == 4'(SLOT_PER_FRAME - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mic  <= '0;
            r_chip <= '0;
            r_sym  <= '0;
            r_slot <= '0;
        end else if (frame_sync) begin
            r_mic  <= '0;
            r_chip <= '0;
            r_sym  <= '0;
            r_slot <= '0;
        end else begin
            r_mic <= w_mic_tc ? 5'd0 : r_mic + 5'd1;
            if (w_mic_tc) begin
                r_chip <= w_chip_tc ? 8'd0 : r_chip + 8'd1;
                if (w_chip_tc) begin
                    r_sym <= w_sym_tc ? 4'd0 : r_sym + 4'd1;
                    if (w_sym_tc) begin
                        r_slot <= w_slot_tc ? 4'd0 : r_slot + 4'd1;
                    end
                end
            end
        end
    end

    assign counter_mic = r_mic;
    assign counter_256 = r_chip;
    assign counter_10  = r_sym;
    assign counter_15  = r_slot;

    assign frame_head = (r_chip == 8'd0) && (r_sym == 4'd0) && (r_slot == 4'd0);
    assign frame_end  = w_chip_tc && w_sym_tc && w_slot_tc;
    assign frame_last = frame_end && w_mic_tc;

`ifdef CPICH_SCHED_SLOT_STROBE_EN
    assign slot_last = w_chip_tc && w_sym_tc && w_mic_tc;
`endif

endmodule

`default_nettype wire

// File: rtl/cpich_sched.sv
// ============================================================================
// cpich_sched
// CPICH stage sequencer: frame-aligned counter chain plus start/run/done FSM.
// Optional slot_strobe output under CPICH_SCHED_SLOT_STROBE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpich_sched
    import cpich_sched_pkg::*;
#(
    parameter int MIC_LEN        = c_DEF_MIC_LEN,
    parameter int SF             = c_DEF_SF,
    parameter int SYM_PER_SLOT   = c_DEF_SYM_PER_SLOT,
    parameter int SLOT_PER_FRAME = c_DEF_SLOT_PER_FRAME,
    parameter int MIN_ARM        = c_DEF_MIN_ARM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] n_frames,
    input  logic       ack,
    input  logic       abort,
    input  logic       frame_sync,
    output logic [4:0] counter_mic,
    output logic [7:0] counter_256,
    output logic [3:0] counter_10,
    output logic [3:0] counter_15,
    output logic       frame_head,
    output logic       frame_end,
    output logic       cpich_start,
    output logic [3:0] frame_cnt,
    output logic       busy,
    output logic       done,
`ifdef CPICH_SCHED_SLOT_STROBE_EN
    output logic       slot_strobe,
`endif
    output logic       sync_err
);

    localparam int                 c_ARM_W   = $clog2(MIN_ARM + 1);
    localparam logic [c_ARM_W-1:0] c_ARM_SAT = c_ARM_W'(MIN_ARM);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_n_frames;
    logic [3:0]         w_n_frames_nxt;
    logic [3:0]         r_frame_cnt;
    logic [3:0]         w_frame_cnt_nxt;
    logic [c_ARM_W-1:0] r_arm_cnt;
    logic [c_ARM_W-1:0] w_arm_cnt_nxt;
    logic               r_sync_err;
    logic               w_sync_err_nxt;
    logic               r_cpich_start;
    logic               w_frame_last;
    logic               w_busy;

    cpich_chip_counter #(
        .MIC_LEN        (MIC_LEN),
        .SF             (SF),
        .SYM_PER_SLOT   (SYM_PER_SLOT),
        .SLOT_PER_FRAME (SLOT_PER_FRAME)
    ) u_chip_counter (
        .clk         (clk),
        .rst         (rst),
        .frame_sync  (frame_sync),
        .counter_mic (counter_mic),
        .counter_256 (counter_256),
        .counter_10  (counter_10),
        .counter_15  (counter_15),
        .frame_head  (frame_head),
        .frame_end   (frame_end),
`ifdef CPICH_SCHED_SLOT_STROBE_EN
        .slot_last   (slot_strobe),
`endif
        .frame_last  (w_frame_last)
    );

    assign w_busy = (r_state == S_ARM) || (r_state == S_RUN);

    always_comb begin
        w_state_nxt     = r_state;
        w_n_frames_nxt  = r_n_frames;
        w_frame_cnt_nxt = r_frame_cnt;
        w_arm_cnt_nxt   = r_arm_cnt;
        w_sync_err_nxt  = r_sync_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt     = S_ARM;
                    w_n_frames_nxt  = (n_frames == 4'd0) ? 4'd1 : n_frames;
                    w_frame_cnt_nxt = 4'd0;
                    w_sync_err_nxt  = 1'b0;
                    w_arm_cnt_nxt   = '0;
                end
            end
            S_ARM: begin
                // A boundary reached before the stage is fully armed is skipped.
                if (w_frame_last && (r_arm_cnt == c_ARM_SAT)) begin
                    w_state_nxt = S_RUN;
                end else if (r_arm_cnt != c_ARM_SAT) begin
                    w_arm_cnt_nxt = r_arm_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (w_frame_last) begin
                    w_frame_cnt_nxt = r_frame_cnt + 4'd1;
                    if ((r_frame_cnt + 4'd1) == r_n_frames) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_busy && frame_sync) begin
            w_state_nxt     = S_IDLE;
            w_sync_err_nxt  = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt;
            w_arm_cnt_nxt   = r_arm_cnt;
        end

        if (abort) begin
            w_state_nxt     = S_IDLE;
            w_n_frames_nxt  = r_n_frames;
            w_frame_cnt_nxt = r_frame_cnt;
            w_arm_cnt_nxt   = r_arm_cnt;
            w_sync_err_nxt  = r_sync_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_n_frames    <= 4'd1;
            r_frame_cnt   <= 4'd0;
            r_arm_cnt     <= '0;
            r_sync_err    <= 1'b0;
            r_cpich_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_n_frames    <= w_n_frames_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_arm_cnt     <= w_arm_cnt_nxt;
            r_sync_err    <= w_sync_err_nxt;
            r_cpich_start <= (w_state_nxt != S_IDLE);
        end
    end

    assign cpich_start = r_cpich_start;
    assign frame_cnt   = r_frame_cnt;
    assign busy        = w_busy;
    assign done        = (r_state == S_DONE);
    assign sync_err    = r_sync_err;

endmodule

`default_nettype wire
